// File: rtl/h80cpu_bus_initiator_if.sv
// h80cpu_bus_initiator_if: core request/response port plus the run/done toggle bus.
// Command encoding: cmd[2] set means write (e.g. write_b=3'b100), clear means read (e.g. read_w=3'b010).
interface h80cpu_bus_initiator_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] wr_data;
  logic              run;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  modport master (
    input  req_valid, req_cmd, req_addr, req_wdata, rd_data, done,
    output req_ready, rsp_valid, rsp_data, rsp_err, addr, cmd, wr_data, run
  );
  modport slave (
    output req_valid, req_cmd, req_addr, req_wdata, rd_data, done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, addr, cmd, wr_data, run
  );
endinterface

// File: rtl/h80cpu_bus_initiator.sv
// h80cpu_bus_initiator: one-slot request buffer driving the run/done toggle bus, one response pulse per transaction.
// Define BUS_TIMEOUT_EN to add a WAIT timeout (rsp_err) followed by a DRAIN state that swallows the late completion.
module h80cpu_bus_initiator #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset,
  h80cpu_bus_initiator_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  logic [1:0]        state;
  logic              buf_full;
  logic [2:0]        buf_cmd;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              done_eq;
  logic              launch;
  logic              complete;
  assign done_eq       = bus.done == bus.run;
  assign bus.req_ready = !buf_full && state != DRAIN;
  // Completion cycle doubles as the idle gap, so a buffered request launches right on it
  assign launch        = buf_full && done_eq && state != DRAIN;
  assign complete      = state == WAIT && done_eq;
`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  assign timeout = state == WAIT && !done_eq && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (reset || launch) ? '0 : cnt + CNT_W'(state == WAIT);
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state         <= IDLE;
      buf_full      <= 1'b0;
      buf_cmd       <= '0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      bus.addr      <= '0;
      bus.cmd       <= '0;
      bus.wr_data   <= '0;
      bus.run       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= complete;
      if (bus.req_valid && bus.req_ready) begin
        buf_full  <= 1'b1;
        buf_cmd   <= bus.req_cmd;
        buf_addr  <= bus.req_addr;
        buf_wdata <= bus.req_wdata;
      end
      if (complete) begin
        bus.rsp_data <= bus.cmd[2] ? '0 : bus.rd_data;
        bus.rsp_err  <= 1'b0;
      end
      if (launch) begin
        bus.addr    <= buf_addr;
        bus.cmd     <= buf_cmd;
        bus.wr_data <= buf_wdata;
        bus.run     <= ~bus.run;
        buf_full    <= 1'b0;
        state       <= WAIT;
      end else if (complete) begin
        state <= IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      if (timeout) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_data  <= '0;
        state         <= DRAIN;
      end
      if (state == DRAIN && done_eq) state <= IDLE;
`endif
    end
endmodule

// File: tb/tb_h80cpu_bus_initiator.sv
// tb_h80cpu_bus_initiator: randomized requests against a behavioural responder and an in-order response model.
module tb_h80cpu_bus_initiator;
  localparam int TO = 8;
  localparam logic [2:0] RD_B = 3'b000, RD_H = 3'b001, RD_W = 3'b010;
  localparam logic [2:0] WR_B = 3'b100, WR_H = 3'b101, WR_W = 3'b110;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0, checks = 0, cyc = 0;
  h80cpu_bus_initiator_if #(.ADDR_W(16), .DATA_W(32)) bus();
  h80cpu_bus_initiator #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  logic resp_en = 1'b1, done_r = 1'b0, done_man = 1'b0, prev_run = 1'b0;
  logic rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;
  int lat = 2, rcnt = 0;
  assign bus.done = resp_en ? done_r : done_man;
  int          done_cyc_q[$], launch_cyc_q[$], rsp_cyc_q[$];
  logic [31:0] done_rd_q[$], launch_wd_q[$], rsp_data_q[$];
  logic [15:0] launch_addr_q[$];
  logic [2:0]  launch_cmd_q[$];
  logic        rsp_err_q[$];
  // Monitor plus responder: completes a run toggle after lat cycles with fresh read data
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      prev_run = 1'b0;
      rcnt = 0;
      done_r = 1'b0;
      bus.rd_data = 32'h0;
    end else begin
      if (bus.rsp_valid) begin
        rsp_cyc_q.push_back(cyc);
        rsp_data_q.push_back(bus.rsp_data);
        rsp_err_q.push_back(bus.rsp_err);
      end
      if (bus.run !== prev_run) begin
        launch_cyc_q.push_back(cyc);
        launch_addr_q.push_back(bus.addr);
        launch_cmd_q.push_back(bus.cmd);
        launch_wd_q.push_back(bus.wr_data);
        prev_run = bus.run;
      end
      if (resp_en) begin
        if (bus.run !== done_r) begin
          if (rcnt >= lat) begin
            bus.rd_data = rd_fixed_en ? rd_fixed : $urandom;
            done_r = bus.run;
            done_cyc_q.push_back(cyc);
            done_rd_q.push_back(bus.rd_data);
            rcnt = 0;
          end else rcnt++;
        end else rcnt = 0;
      end
    end
  end
  function automatic bit is_wr(input logic [2:0] c);
    return c == WR_B || c == WR_H || c == WR_W;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic clear_q();
    done_cyc_q.delete(); launch_cyc_q.delete(); rsp_cyc_q.delete();
    done_rd_q.delete(); launch_wd_q.delete(); rsp_data_q.delete();
    launch_addr_q.delete(); launch_cmd_q.delete(); rsp_err_q.delete();
  endtask
  task automatic send(input logic [2:0] c, input logic [15:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_addr = a; bus.req_wdata = d;
    while (!bus.req_ready && n < 100) begin tick(); n++; end
    tick();
    acc = cyc;
    bus.req_valid = 1'b0;
    checks++;
    if (n >= 100) begin errors++; $display("FAIL send_accept: req_ready stayed 0 for %0d cycles, required 1", n); end
  endtask
  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_cyc_q.size() < n && t < 300) begin tick(); t++; end
    checks++;
    if (rsp_cyc_q.size() < n) begin errors++; $display("FAIL wait_rsp: got %0d responses, required %0d", rsp_cyc_q.size(), n); end
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    tick(3);
    checks += 8;
    if (bus.run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b, required 0", bus.run); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready); end
    if (bus.addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", bus.addr); end
    if (bus.cmd !== 3'h0) begin errors++; $display("FAIL reset_cmd: got %h, required 0", bus.cmd); end
    if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h, required 0", bus.wr_data); end
    if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h, required 0", bus.rsp_data); end
    if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b, required 0", bus.rsp_err); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_write();
    int acc;
    clear_q(); lat = 2;
    send(WR_B, 16'h0000, 32'h41, acc);
    wait_rsp(1);
    checks += 8;
    if (launch_cyc_q[0] !== acc + 1) begin errors++; $display("FAIL write_launch_cyc: got %0d, required %0d", launch_cyc_q[0], acc + 1); end
    if (launch_cmd_q[0] !== WR_B) begin errors++; $display("FAIL write_cmd: got %h, required %h", launch_cmd_q[0], WR_B); end
    if (launch_addr_q[0] !== 16'h0) begin errors++; $display("FAIL write_addr: got %h, required 0", launch_addr_q[0]); end
    if (launch_wd_q[0] !== 32'h41) begin errors++; $display("FAIL write_wr_data: got %h, required 41", launch_wd_q[0]); end
    if (bus.run !== 1'b1) begin errors++; $display("FAIL write_run: got %b, required 1", bus.run); end
    if (rsp_data_q[0] !== 32'h0) begin errors++; $display("FAIL write_rsp_data: got %h, required 0", rsp_data_q[0]); end
    if (rsp_err_q[0] !== 1'b0) begin errors++; $display("FAIL write_rsp_err: got %b, required 0", rsp_err_q[0]); end
    if (rsp_cyc_q[0] !== done_cyc_q[0] + 1) begin errors++; $display("FAIL write_rsp_cyc: got %0d, required %0d", rsp_cyc_q[0], done_cyc_q[0] + 1); end
  endtask
  task automatic test_read();
    int acc;
    clear_q(); lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'hDEADBEEF;
    send(RD_W, 16'h0010, $urandom, acc);
    wait_rsp(1);
    rd_fixed_en = 1'b0;
    checks += 4;
    if (launch_addr_q[0] !== 16'h0010) begin errors++; $display("FAIL read_addr: got %h, required 0010", launch_addr_q[0]); end
    if (rsp_data_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rsp_data: got %h, required deadbeef", rsp_data_q[0]); end
    if (rsp_err_q[0] !== 1'b0) begin errors++; $display("FAIL read_rsp_err: got %b, required 0", rsp_err_q[0]); end
    if (rsp_cyc_q[0] !== done_cyc_q[0] + 1) begin errors++; $display("FAIL read_rsp_cyc: got %0d, required %0d", rsp_cyc_q[0], done_cyc_q[0] + 1); end
  endtask
  task automatic test_back_to_back();
    int a0, a1;
    logic r0;
    clear_q(); lat = 3;
    r0 = bus.run;
    send(WR_W, 16'h1234, 32'hCAFE0001, a0);
    send(RD_H, 16'h0042, 32'h0, a1);
    checks += 6;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %b, required 0", bus.req_ready); end
    wait_rsp(2);
    if (launch_cyc_q[1] !== rsp_cyc_q[0]) begin errors++; $display("FAIL b2b_launch_with_rsp: launch %0d, required %0d", launch_cyc_q[1], rsp_cyc_q[0]); end
    if (bus.run !== r0) begin errors++; $display("FAIL b2b_run: got %b, required %b", bus.run, r0); end
    if (rsp_data_q[0] !== 32'h0) begin errors++; $display("FAIL b2b_rsp0: got %h, required 0", rsp_data_q[0]); end
    if (rsp_data_q[1] !== done_rd_q[1]) begin errors++; $display("FAIL b2b_rsp1: got %h, required %h", rsp_data_q[1], done_rd_q[1]); end
    if (launch_addr_q[1] !== 16'h0042) begin errors++; $display("FAIL b2b_addr1: got %h, required 0042", launch_addr_q[1]); end
  endtask
  task automatic test_random();
    logic [2:0] cmds [6];
    logic [2:0] rc [16];
    logic [15:0] ra [16];
    logic [31:0] rw [16];
    int acc [16];
    int exp_l;
    logic [31:0] exp_d;
    cmds = '{RD_B, RD_H, RD_W, WR_B, WR_H, WR_W};
    clear_q();
    for (int i = 0; i < 16; i++) begin
      lat = $urandom_range(1, 4);
      rc[i] = cmds[$urandom_range(0, 5)];
      ra[i] = 16'($urandom);
      rw[i] = $urandom;
      tick($urandom_range(0, 2));
      send(rc[i], ra[i], rw[i], acc[i]);
    end
    wait_rsp(16);
    for (int i = 0; i < 16; i++) begin
      exp_d = is_wr(rc[i]) ? 32'h0 : done_rd_q[i];
      exp_l = (i == 0 || acc[i] > done_cyc_q[i-1]) ? acc[i] + 1 : done_cyc_q[i-1] + 1;
      checks += 6;
      if (rsp_data_q[i] !== exp_d) begin errors++; $display("FAIL rand_rsp_data[%0d]: got %h, required %h", i, rsp_data_q[i], exp_d); end
      if (rsp_err_q[i] !== 1'b0) begin errors++; $display("FAIL rand_rsp_err[%0d]: got %b, required 0", i, rsp_err_q[i]); end
      if (rsp_cyc_q[i] !== done_cyc_q[i] + 1) begin errors++; $display("FAIL rand_rsp_cyc[%0d]: got %0d, required %0d", i, rsp_cyc_q[i], done_cyc_q[i] + 1); end
      if (launch_cyc_q[i] !== exp_l) begin errors++; $display("FAIL rand_launch_cyc[%0d]: got %0d, required %0d", i, launch_cyc_q[i], exp_l); end
      if (launch_cmd_q[i] !== rc[i] || launch_addr_q[i] !== ra[i]) begin errors++; $display("FAIL rand_launch_cmd_addr[%0d]: got %h/%h, required %h/%h", i, launch_cmd_q[i], launch_addr_q[i], rc[i], ra[i]); end
      if (launch_wd_q[i] !== rw[i]) begin errors++; $display("FAIL rand_launch_wdata[%0d]: got %h, required %h", i, launch_wd_q[i], rw[i]); end
    end
  endtask
  task automatic test_stray_done();
    int acc, k, j;
    logic [31:0] exp_d;
    clear_q();
    done_man = ~bus.run; resp_en = 1'b0;
    send(RD_B, 16'h0077, 32'h0, acc);
    tick(5);
    checks += 5;
    if (launch_cyc_q.size() !== 0) begin errors++; $display("FAIL stray_no_launch: got %0d launches, required 0", launch_cyc_q.size()); end
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stray_ready: got %b, required 0", bus.req_ready); end
    done_man = bus.run; k = cyc;
    tick();
    if (launch_cyc_q[0] !== k + 1) begin errors++; $display("FAIL stray_launch_cyc: got %0d, required %0d", launch_cyc_q[0], k + 1); end
    exp_d = bus.rd_data;
    done_man = bus.run; j = cyc;
    tick(2);
    if (rsp_cyc_q[0] !== j + 1) begin errors++; $display("FAIL stray_rsp_cyc: got %0d, required %0d", rsp_cyc_q[0], j + 1); end
    if (rsp_data_q[0] !== exp_d) begin errors++; $display("FAIL stray_rsp_data: got %h, required %h", rsp_data_q[0], exp_d); end
    done_r = done_man; resp_en = 1'b1;
  endtask
  task automatic test_reset_mid();
    int acc;
    clear_q();
    done_man = bus.run; resp_en = 1'b0;
    send(RD_W, 16'h0100, 32'h0, acc);
    tick();
    checks += 6;
    if (launch_cyc_q.size() !== 1) begin errors++; $display("FAIL midrst_launched: got %0d launches, required 1", launch_cyc_q.size()); end
    reset = 1'b1; done_man = 1'b0;
    tick();
    if (bus.run !== 1'b0) begin errors++; $display("FAIL midrst_run: got %b, required 0", bus.run); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b, required 1", bus.req_ready); end
    reset = 1'b0; done_r = 1'b0; resp_en = 1'b1;
    clear_q();
    tick(3);
    if (rsp_cyc_q.size() !== 0) begin errors++; $display("FAIL midrst_dropped: got %0d responses, required 0", rsp_cyc_q.size()); end
    lat = 1;
    send(RD_W, 16'h0200, 32'h0, acc);
    wait_rsp(1);
    if (rsp_data_q[0] !== done_rd_q[0]) begin errors++; $display("FAIL midrst_fresh_read: got %h, required %h", rsp_data_q[0], done_rd_q[0]); end
  endtask
`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int acc, k, bad = 0;
    clear_q();
    done_man = bus.run; resp_en = 1'b0;
    send(RD_W, 16'h0300, 32'h0, acc);
    wait_rsp(1);
    checks += 6;
    if (rsp_cyc_q[0] !== acc + 1 + TO) begin errors++; $display("FAIL to_rsp_cyc: got %0d, required %0d", rsp_cyc_q[0], acc + 1 + TO); end
    if (rsp_err_q[0] !== 1'b1) begin errors++; $display("FAIL to_rsp_err: got %b, required 1", rsp_err_q[0]); end
    if (rsp_data_q[0] !== 32'h0) begin errors++; $display("FAIL to_rsp_data: got %h, required 0", rsp_data_q[0]); end
    for (int i = 0; i < 5; i++) begin if (bus.req_ready) bad++; tick(); end
    if (bad != 0) begin errors++; $display("FAIL to_drain_ready: req_ready high %0d cycles, required 0", bad); end
    done_man = bus.run; k = cyc;
    tick();
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL to_drain_exit: req_ready %b at %0d, required 1", bus.req_ready, k + 1); end
    tick(10);
    if (rsp_cyc_q.size() !== 1) begin errors++; $display("FAIL to_second_rsp: got %0d responses, required 1", rsp_cyc_q.size()); end
    done_r = done_man; resp_en = 1'b1;
  endtask
`endif
  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_stray_done();
    test_reset_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
